// File: rtl/minmax_pkg.sv
// Shared selection types and mode constants for sel_minmax and its users.
// MIN offers the smallest key, MAX offers the largest.
package minmax_pkg;
    localparam bit MIN = 1'b1;
    localparam bit MAX = 1'b0;
    localparam int DATA_W = 8;

    typedef logic [DATA_W:0] key_t;
endpackage

// File: rtl/sel_minmax.sv
// Combinational min/max selector over IN keys.
// Returns the winning key plus a one-hot winner mask; the lowest index wins ties.
module sel_minmax
    import minmax_pkg::*;
#(
    parameter int DATA = 9,
    parameter int IN = 8,
    parameter bit MINMAX = MIN,
    parameter bit ACT = 1'b1
) (
    input  logic [IN-1:0][DATA-1:0] in,
    output logic [DATA-1:0]         out,
    output logic [IN-1:0]           out_vec
);
    logic [DATA-1:0] best;
    logic [IN-1:0]   hot;
    logic            better;

    always_comb begin
        best = in[0];
        hot = '0;
        hot[0] = 1'b1;
        better = 1'b0;
        for (int i = 1; i < IN; i++) begin
            // Strict compare keeps the earlier index on equal keys.
            better = (MINMAX == MIN) ? (in[i] < best) : (in[i] > best);
            if (better) begin
                best = in[i];
                hot = '0;
                hot[i] = 1'b1;
            end
        end
        out = best;
        out_vec = ACT ? hot : ~hot;
    end
endmodule

// File: rtl/minmax_queue.sv
// Priority buffer that always offers its min (or max) stored entry.
// Define MINMAX_Q_BYPASS_EN to pass a value straight through when empty.
module minmax_queue
    import minmax_pkg::*;
#(
    parameter bit MINMAX_ = MIN,
    parameter int DEPTH = 8,
    parameter int DATA = 8,
    localparam int CNT = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DATA-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic [CNT-1:0]  cnt,
    output logic            full,
    output logic            empty
);
    logic [DEPTH-1:0]           valid_q;
    logic [DATA-1:0]            data_q [DEPTH];
    logic [CNT-1:0]             cnt_q;
    logic [DEPTH-1:0][DATA:0]   keys;
    logic [DATA:0]              win_key;
    logic [DEPTH-1:0]           win_vec;
    logic [DEPTH-1:0]           free_vec;
    logic                       stored;
    logic                       byp;
    logic                       push;
    logic                       pop;

    // Invalid slots carry the losing top bit, so they never win.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            keys[i] = (MINMAX_ == MIN) ? {~valid_q[i], data_q[i]}
                                       : {valid_q[i], data_q[i]};
        end
    end

    sel_minmax #(
        .DATA(DATA + 1),
        .IN(DEPTH),
        .MINMAX(MINMAX_),
        .ACT(1'b1)
    ) u_sel (
        .in(keys),
        .out(win_key),
        .out_vec(win_vec)
    );

    always_comb begin
        free_vec = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_vec = '0;
                free_vec[i] = 1'b1;
            end
        end
    end

    assign stored = |valid_q;
    assign full = (cnt_q == CNT'(DEPTH));
    assign empty = (cnt_q == '0);
    assign in_ready = ~full;
    assign cnt = cnt_q;

`ifdef MINMAX_Q_BYPASS_EN
    assign byp = empty & in_valid & out_ready & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign push = in_valid & ~full & ~byp;
    assign pop = stored & out_ready;
    assign out_valid = stored | byp;

    always_comb begin
        out_data = '0;
        if (byp) begin
            out_data = in_data;
        end else if (stored) begin
            out_data = win_key[DATA-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            cnt_q <= '0;
        end else begin
            valid_q <= (valid_q & ~(pop ? win_vec : '0))
                     | (push ? free_vec : '0);
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && free_vec[i]) begin
                data_q[i] <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_minmax_queue.sv
// Directed and random checks of minmax_queue in min and max modes.
// Both instances share stimulus; the min instance is scoreboarded randomly.
module tb_minmax_queue;
    import minmax_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       a_in_ready, a_out_valid, a_full, a_empty;
    logic [7:0] a_out_data;
    logic [2:0] a_cnt;
    logic       b_in_ready, b_out_valid, b_full, b_empty;
    logic [7:0] b_out_data;
    logic [2:0] b_cnt;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [$];
    logic [7:0] model [$];

    always #5 clk = ~clk;

    minmax_queue #(.MINMAX_(MIN), .DEPTH(4), .DATA(8)) dut_min (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .cnt(a_cnt),
        .full(a_full), .empty(a_empty)
    );

    minmax_queue #(.MINMAX_(MAX), .DEPTH(4), .DATA(8)) dut_max (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .cnt(b_cnt),
        .full(b_full), .empty(b_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        in_valid = 1'b1;
        in_data = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_min(input string tag);
        #1;
        chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        chk(tag, 32'(a_out_data), 32'(sb.pop_front()));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] mn;
        int mi;
        logic ev, byp, pu, po, fl;
        logic [7:0] ed;

        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_full", 32'(a_full), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);

        push(8'h30);
        push(8'h10);
        push(8'h20);
        #1;
        chk("t2_cnt", 32'(a_cnt), 32'd3);
        chk("t2_max_out", 32'(b_out_data), 32'h30);
        sb.push_back(8'h10);
        sb.push_back(8'h20);
        sb.push_back(8'h30);
        pop_min("t2_pop0");
        pop_min("t2_pop1");
        pop_min("t2_pop2");
        #1;
        chk("t2_empty", 32'(a_empty), 32'd1);
        chk("t2_drained", 32'(a_out_valid), 32'd0);

        push(8'h05);
        push(8'hFF);
        push(8'h07);
        push(8'h06);
        #1;
        chk("t3_full", 32'(a_full), 32'd1);
        chk("t3_in_ready", 32'(a_in_ready), 32'd0);
        in_valid = 1'b1;
        in_data = 8'h02;
        out_ready = 1'b1;
        #1;
        chk("t3_pop", 32'(a_out_data), 32'h05);
        chk("t3_max_pop", 32'(b_out_data), 32'hFF);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("t3_refused_cnt", 32'(a_cnt), 32'd3);
        chk("t3_refused_out", 32'(a_out_data), 32'h06);
        push(8'h01);
        #1;
        chk("t3_new_min", 32'(a_out_data), 32'h01);
        chk("t3_cnt4", 32'(a_cnt), 32'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("t3_flush_cnt", 32'(a_cnt), 32'd0);

        push(8'h00);
        push(8'hFF);
        #1;
        chk("t4_max0", 32'(b_out_data), 32'hFF);
        chk("t4_min0", 32'(a_out_data), 32'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("t4_max1", 32'(b_out_data), 32'h00);
        chk("t4_min1", 32'(a_out_data), 32'hFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("t4_max_empty", 32'(b_empty), 32'd1);

        push(8'h11);
        push(8'h22);
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h40);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data = 8'h40 + 8'(k);
            out_ready = 1'b1;
            #1;
            chk("t5_out", 32'(a_out_data), 32'(sb.pop_front()));
            tick();
            #1;
            chk("t5_cnt", 32'(a_cnt), 32'd2);
        end
        out_ready = 1'b0;
        flush = 1'b1;
        in_data = 8'h03;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_flush_cnt", 32'(a_cnt), 32'd0);
        chk("t5_flush_valid", 32'(a_out_valid), 32'd0);

        in_valid = 1'b1;
        in_data = 8'h42;
        out_ready = 1'b1;
        #1;
`ifdef MINMAX_Q_BYPASS_EN
        chk("t6_byp_valid", 32'(a_out_valid), 32'd1);
        chk("t6_byp_data", 32'(a_out_data), 32'h42);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("t6_byp_cnt", 32'(a_cnt), 32'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("t6_byp_flush", 32'(a_out_valid), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
`else
        chk("t6_nobyp_valid", 32'(a_out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("t6_next_valid", 32'(a_out_valid), 32'd1);
        chk("t6_next_data", 32'(a_out_data), 32'h42);
        chk("t6_next_cnt", 32'(a_cnt), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
`endif

        for (int c = 0; c < 1000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 49) == 0);
            mn = 8'hFF;
            mi = 0;
            foreach (model[j]) begin
                if (model[j] < mn || j == 0) begin
                    mn = model[j];
                    mi = j;
                end
            end
            fl = flush;
            byp = 1'b0;
`ifdef MINMAX_Q_BYPASS_EN
            byp = (model.size() == 0) && in_valid && out_ready && !fl;
`endif
            ev = byp || (model.size() > 0);
            ed = byp ? in_data : ((model.size() > 0) ? mn : 8'h00);
            #1;
            chk("rnd_valid", 32'(a_out_valid), 32'(ev));
            chk("rnd_data", 32'(a_out_data), 32'(ed));
            chk("rnd_cnt", 32'(a_cnt), 32'(model.size()));
            chk("rnd_full", 32'(a_full), 32'(model.size() == 4));
            po = (model.size() > 0) && out_ready;
            pu = in_valid && (model.size() < 4) && !byp;
            if (fl) begin
                model.delete();
            end else begin
                if (po) model.delete(mi);
                if (pu) model.push_back(in_data);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
